// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit: MIPS IF stage - owns the PC, fetches over req/ack, 2-deep queue |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] DatoPCPlus4,
  output logic [31:0] DatoInstrD,
  output logic        EnableIFID
);

  localparam logic [31:0] c_wordBytes = 32'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    BUSY_KILL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_reqAddr;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_fifoPc4   [2];
  logic [31:0] r_fifoInstr [2];

  logic        w_pop;
  logic        w_push;
  logic        w_wrIdx;
  logic [1:0]  w_countNext;
  logic [31:0] w_reqNext;

  assign imem_req    = (r_state == BUSY) || (r_state == BUSY_KILL);
  assign imem_addr   = r_reqAddr;
  assign w_reqNext   = r_reqAddr + c_wordBytes;
  assign w_pop       = EnableIFID & ~branch_taken;
  assign w_push      = imem_ack & (r_state == BUSY) & ~branch_taken;
  assign w_countNext = r_count - {1'b0, w_pop} + {1'b0, w_push};
  // Writes only happen with count 0 or 1, so the free slot is head xor count[0].
  assign w_wrIdx     = r_head ^ r_count[0];

  always_comb begin
    EnableIFID  = 1'b0;
    DatoPCPlus4 = '0;
    DatoInstrD  = '0;
    if (!rst) begin
      if (branch_taken) begin
        EnableIFID = 1'b1;
      end else if (r_count != 2'd0) begin
        EnableIFID  = ~stall_i;
        DatoPCPlus4 = r_fifoPc4[r_head];
        DatoInstrD  = r_fifoInstr[r_head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoPc4[w_wrIdx]   <= w_reqNext;
      r_fifoInstr[w_wrIdx] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_reqAddr <= '0;
      r_count   <= '0;
      r_head    <= 1'b0;
    end else if (branch_taken) begin
      // Redirect flushes the queue; an outstanding request must still be retired.
      r_count <= '0;
      r_pc    <= branch_target;
      case (r_state)
        BUSY:      r_state <= imem_ack ? IDLE : BUSY_KILL;
        BUSY_KILL: if (imem_ack) r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end else begin
      r_count <= w_countNext;
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case (r_state)
        IDLE: begin
          if (w_countNext <= 2'd1) begin
            r_state   <= BUSY;
            r_reqAddr <= r_pc;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            r_pc <= w_reqNext;
            if (w_countNext <= 2'd1) begin
              r_reqAddr <= w_reqNext;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        BUSY_KILL: begin
          if (imem_ack) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit: vectors, corner sequences and random stream vs. scoreboard   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] c_resetPc = 32'h0000_0000;
  localparam logic [31:0] c_salt    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] DatoPCPlus4;
  logic [31:0] DatoInstrD;
  logic        EnableIFID;

  fetch_unit #(.RESET_PC(c_resetPc)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .DatoPCPlus4(DatoPCPlus4),
    .DatoInstrD(DatoInstrD), .EnableIFID(EnableIFID)
  );

  always #5 clk = ~clk;

  // Memory: acks after memWait cycles of a held request, word = addr ^ salt.
  int cfgWait  = 0;
  bit randWait = 1'b0;
  int memWait  = 0;
  int waitCnt  = 0;
  assign imem_ack   = imem_req && (waitCnt >= memWait);
  assign imem_rdata = imem_addr ^ c_salt;
  always @(posedge clk) begin
    if (!imem_req || imem_ack) begin
      waitCnt <= 0;
      memWait <= randWait ? int'($urandom_range(0, 3)) : cfgWait;
    end else begin
      waitCnt <= waitCnt + 1;
    end
  end

  // Address must not move while a request is waiting.
  logic        pendV;
  logic [31:0] pendA;
  int addrErr = 0;
  int addrChk = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pendV <= 1'b0;
      pendA <= '0;
    end else begin
      if (pendV) begin
        addrChk <= addrChk + 1;
        if (!imem_req || imem_addr != pendA) addrErr <= addrErr + 1;
      end
      pendV <= imem_req && !imem_ack;
      pendA <= imem_addr;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: delivered words are consecutive from the last start address.
  logic [31:0] expA = c_resetPc;
  int          idle = 0;
  logic [31:0] sReq, sAck, sEn, sAddr, sPc4, sIns;

  task automatic step(input bit st, input bit b, input logic [31:0] tgt);
    stall_i       = st;
    branch_taken  = b;
    branch_target = tgt;
    @(negedge clk);
    sReq  = 32'(imem_req);
    sAck  = 32'(imem_ack);
    sEn   = 32'(EnableIFID);
    sAddr = imem_addr;
    sPc4  = DatoPCPlus4;
    sIns  = DatoInstrD;
    if (b) begin
      chk("bubble_en", sEn, 32'd1);
      chk("bubble_pc4", sPc4, 32'd0);
      chk("bubble_instr", sIns, 32'd0);
      expA = tgt;
      idle = 0;
    end else if (sEn != 0) begin
      chk("stream_pc4", sPc4, expA + 32'd4);
      chk("stream_instr", sIns, expA ^ c_salt);
      expA = expA + 32'd4;
      idle = 0;
    end else if (!st) begin
      idle++;
      if (idle > 16) begin
        checks++;
        errors++;
        $display("FAIL liveness: %0d idle cycles, limit 16", idle);
        idle = 0;
      end
    end
    if (st && !b) chk("stall_hold_en", sEn, 32'd0);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
  endtask

  task automatic doReset();
    rst           = 1'b1;
    stall_i       = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'hDEAD_BEEC;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_en", 32'(EnableIFID), 32'd0);
    chk("rst_pc4", DatoPCPlus4, 32'd0);
    chk("rst_instr", DatoInstrD, 32'd0);
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    expA = c_resetPc;
    idle = 0;
  endtask

  // what: 0 req waiting, 1 ack, 2 req, 3 enable
  task automatic runUntil(input int what, input bit st, input string name);
    bit hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      step(st, 1'b0, 32'd0);
      case (what)
        0:       hit = (sReq != 0) && (sAck == 0);
        1:       hit = (sAck != 0);
        2:       hit = (sReq != 0);
        default: hit = (sEn != 0);
      endcase
    end
    chk({name, "_reached"}, 32'(hit), 32'd1);
  endtask

  typedef struct {
    bit          st;
    bit          b;
    logic [31:0] tgt;
    bit          req;
    logic [31:0] addr;
    bit          en;
    logic [31:0] pc4;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int acks;
    int last;
    int nDel;
    bit hit;

    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,   32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h4,   32'hA5A5_0000};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h8,   32'hA5A5_0004};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'hC,   32'hA5A5_0008};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hC,   32'hA5A5_0008};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,   32'hA5A5_0008};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'h10,  32'hA5A5_000C};
    tbl[8]  = '{1'b0, 1'b1, 32'h400,       1'b1, 32'h14,        1'b1, 32'h0,   32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h400,       1'b0, 32'h0,   32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h404,       1'b1, 32'h404, 32'hA5A5_0400};
    tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h408,       1'b1, 32'h0,   32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,   32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0,   32'h5A5A_FFFC};

    // Zero-wait stream, stall, redirects and address wrap, cycle by cycle.
    cfgWait = 0;
    doReset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].b, tbl[i].tgt);
      chk($sformatf("vec%0d_req", i), sReq, 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), sAddr, tbl[i].addr);
      chk($sformatf("vec%0d_en", i), sEn, 32'(tbl[i].en));
      chk($sformatf("vec%0d_pc4", i), sPc4, tbl[i].pc4);
      chk($sformatf("vec%0d_instr", i), sIns, tbl[i].ins);
    end

    // Long stall mid-stream: queue fills, requests stop, release resumes without gap.
    doReset();
    repeat (6) step(1'b0, 1'b0, 32'd0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'd0);
      if (sAck != 0) acks++;
    end
    chk("stall_ack_limit", 32'(acks <= 2), 32'd1);
    chk("stall_req_low", sReq, 32'd0);
    chk("stall_en_low", sEn, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("release_no_gap", sEn, 32'd1);
    repeat (10) step(1'b0, 1'b0, 32'd0);

    // Three wait states per word: one delivery every four cycles.
    cfgWait = 3;
    doReset();
    last = -1;
    nDel = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (sEn != 0) begin
        if (last >= 0) chk("wait_period", 32'(i - last), 32'd4);
        last = i;
        nDel++;
      end
    end
    chk("wait_count", 32'(nDel), 32'd9);

    // Redirect while a request is waiting: old ack discarded, target fetched next.
    doReset();
    runUntil(0, 1'b0, "kill_wait");
    step(1'b0, 1'b1, 32'h400);
    runUntil(1, 1'b0, "kill_old_ack");
    chk("kill_old_addr", sAddr, 32'h0);
    runUntil(2, 1'b0, "kill_new_req");
    chk("redirect_addr", sAddr, 32'h400);
    runUntil(3, 1'b0, "redirect_deliver");
    chk("redirect_pc4", sPc4, 32'h404);
    chk("redirect_instr", sIns, 32'h400 ^ c_salt);

    // Redirect on the same cycle as an ack that would fill the stalled queue.
    cfgWait = 2;
    doReset();
    runUntil(1, 1'b1, "flush_first_ack");
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (imem_ack) begin
        step(1'b1, 1'b1, 32'h800);
        hit = 1'b1;
      end else begin
        step(1'b1, 1'b0, 32'd0);
      end
    end
    chk("flush_ack_seen", 32'(hit), 32'd1);
    chk("flush_en", sEn, 32'd1);
    chk("flush_instr", sIns, 32'd0);
    runUntil(3, 1'b0, "flush_deliver");
    chk("flush_first_pc4", sPc4, 32'h804);

    // Reset during a waiting request at a non-reset address.
    cfgWait = 3;
    doReset();
    runUntil(3, 1'b0, "mw_first_word");
    runUntil(0, 1'b0, "mw_wait");
    chk("mw_pre_addr", sAddr, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("mw_req", 32'(imem_req), 32'd0);
    chk("mw_addr", imem_addr, 32'd0);
    chk("mw_en", 32'(EnableIFID), 32'd0);
    chk("mw_pc4", DatoPCPlus4, 32'd0);
    chk("mw_instr", DatoInstrD, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    expA = c_resetPc;
    idle = 0;
    runUntil(2, 1'b0, "mw_restart");
    chk("mw_restart_addr", sAddr, c_resetPc);
    runUntil(3, 1'b0, "mw_restart_deliver");

    // Random stalls, redirects and memory latencies against the scoreboard.
    randWait = 1'b1;
    doReset();
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom);
    end

    chk("addr_stable", 32'(addrErr), 32'd0);
    chk("addr_watch_active", 32'(addrChk > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
